// File: rtl/easyaxi_rd_slice.sv
`default_nettype none
// ============================================================================
// Module   : easyaxi_rd_slice_skid
// Purpose  : Two-entry skid buffer for one valid/ready channel. The valid,
//            ready and payload outputs all come straight from flops, so no
//            combinational path runs from the input side to the output side.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            i_valid/o_ready     - upstream handshake
//            i_data              - upstream payload
//            o_valid/i_ready     - downstream handshake
//            o_data              - downstream payload (main register)
//            o_empty_next        - holds no beat after the coming edge
// Revision : 1.0 - initial release
// ============================================================================
module easyaxi_rd_slice_skid #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [W-1:0] o_data,
   output logic         o_empty_next
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_next;
   logic           r_valid;
   logic           r_ready;
   logic [W-1:0]   r_main;
   logic [W-1:0]   r_skid;
   logic           w_accept;
   logic           w_drain;

   assign w_accept = i_valid & r_ready;
   assign w_drain  = r_valid & i_ready;

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_EMPTY: if (w_accept) w_next = ST_ONE;
         ST_ONE: begin
            if (w_accept && !w_drain)      w_next = ST_FULL;
            else if (!w_accept && w_drain) w_next = ST_EMPTY;
         end
         ST_FULL:  if (w_drain) w_next = ST_ONE;
         default:  w_next = ST_EMPTY;
      endcase
   end

   // Valid and ready are both functions of the next state, registered, so
   // ready falls on the same edge that fills the skid entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_EMPTY;
         r_valid <= 1'b0;
         r_ready <= 1'b0;
      end else begin
         r_state <= w_next;
         r_valid <= (w_next != ST_EMPTY);
         r_ready <= (w_next != ST_FULL);
      end
   end

   // Payload needs no reset: it is only observed while valid is high.
   always_ff @(posedge clk) begin
      case (r_state)
         ST_EMPTY: begin
            if (w_accept) r_main <= i_data;
         end
         ST_ONE: begin
            if (w_accept) begin
               if (w_drain) r_main <= i_data;
               else         r_skid <= i_data;
            end
         end
         ST_FULL: begin
            if (w_drain) r_main <= r_skid;
         end
         default: ;
      endcase
   end

   assign o_valid      = r_valid;
   assign o_ready      = r_ready;
   assign o_data       = r_main;
   assign o_empty_next = (w_next == ST_EMPTY);

endmodule

// ============================================================================
// Module   : easyaxi_rd_slice
// Purpose  : AXI read register slice. AR (master->slave) and R (slave->master)
//            each pass through an independent two-entry skid buffer; beats are
//            never reordered, dropped or modified.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            s_ar*               - AR channel from master
//            m_ar*               - AR channel to slave
//            m_r*                - R channel from slave
//            s_r*                - R channel to master
//            idle                - neither channel holds a beat
// Revision : 1.0 - initial release
// ============================================================================
module easyaxi_rd_slice #(
   parameter int ID_W    = 4,
   parameter int ADDR_W  = 32,
   parameter int LEN_W   = 8,
   parameter int SIZE_W  = 3,
   parameter int BURST_W = 2,
   parameter int USER_W  = 4,
   parameter int DATA_W  = 32,
   parameter int RESP_W  = 2
) (
   input  logic               clk,
   input  logic               rst,
   // AR from master
   input  logic               s_arvalid,
   output logic               s_arready,
   input  logic [ID_W-1:0]    s_arid,
   input  logic [ADDR_W-1:0]  s_araddr,
   input  logic [LEN_W-1:0]   s_arlen,
   input  logic [SIZE_W-1:0]  s_arsize,
   input  logic [BURST_W-1:0] s_arburst,
   input  logic [USER_W-1:0]  s_aruser,
   // AR to slave
   output logic               m_arvalid,
   input  logic               m_arready,
   output logic [ID_W-1:0]    m_arid,
   output logic [ADDR_W-1:0]  m_araddr,
   output logic [LEN_W-1:0]   m_arlen,
   output logic [SIZE_W-1:0]  m_arsize,
   output logic [BURST_W-1:0] m_arburst,
   output logic [USER_W-1:0]  m_aruser,
   // R from slave
   input  logic               m_rvalid,
   output logic               m_rready,
   input  logic [ID_W-1:0]    m_rid,
   input  logic [DATA_W-1:0]  m_rdata,
   input  logic [RESP_W-1:0]  m_rresp,
   input  logic               m_rlast,
   input  logic [USER_W-1:0]  m_ruser,
   // R to master
   output logic               s_rvalid,
   input  logic               s_rready,
   output logic [ID_W-1:0]    s_rid,
   output logic [DATA_W-1:0]  s_rdata,
   output logic [RESP_W-1:0]  s_rresp,
   output logic               s_rlast,
   output logic [USER_W-1:0]  s_ruser,
   // status
   output logic               idle
);

   localparam int c_ar_w = ID_W + ADDR_W + LEN_W + SIZE_W + BURST_W + USER_W;
   localparam int c_r_w  = ID_W + DATA_W + RESP_W + 1 + USER_W;

   logic [c_ar_w-1:0] w_ar_in;
   logic [c_ar_w-1:0] w_ar_out;
   logic [c_r_w-1:0]  w_r_in;
   logic [c_r_w-1:0]  w_r_out;
   logic              w_ar_empty_next;
   logic              w_r_empty_next;
   logic              r_idle;

   assign w_ar_in = {s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_aruser};
   assign {m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_aruser} = w_ar_out;

   assign w_r_in = {m_rid, m_rdata, m_rresp, m_rlast, m_ruser};
   assign {s_rid, s_rdata, s_rresp, s_rlast, s_ruser} = w_r_out;

   easyaxi_rd_slice_skid #(.W(c_ar_w)) u_ar_skid (
      .clk          (clk),
      .rst          (rst),
      .i_valid      (s_arvalid),
      .o_ready      (s_arready),
      .i_data       (w_ar_in),
      .o_valid      (m_arvalid),
      .i_ready      (m_arready),
      .o_data       (w_ar_out),
      .o_empty_next (w_ar_empty_next)
   );

   easyaxi_rd_slice_skid #(.W(c_r_w)) u_r_skid (
      .clk          (clk),
      .rst          (rst),
      .i_valid      (m_rvalid),
      .o_ready      (m_rready),
      .i_data       (w_r_in),
      .o_valid      (s_rvalid),
      .i_ready      (s_rready),
      .o_data       (w_r_out),
      .o_empty_next (w_r_empty_next)
   );

   // Registered from next-state so idle tracks the channel states on the
   // same edge as the valids.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_idle <= 1'b1;
      else     r_idle <= w_ar_empty_next & w_r_empty_next;
   end

   assign idle = r_idle;

endmodule
`default_nettype wire

// File: tb/tb_easyaxi_rd_slice.sv
`default_nettype none
// ============================================================================
// Module   : tb_easyaxi_rd_slice
// Purpose  : Scoreboard bench for easyaxi_rd_slice: driven beats are pushed
//            to per-channel queues on acceptance and compared when the slice
//            hands them onward.
// Revision : 1.0 - initial release
// ============================================================================
module tb_easyaxi_rd_slice;

   logic        clk;
   logic        rst;
   logic        s_arvalid, s_arready;
   logic [3:0]  s_arid;
   logic [31:0] s_araddr;
   logic [7:0]  s_arlen;
   logic [2:0]  s_arsize;
   logic [1:0]  s_arburst;
   logic [3:0]  s_aruser;
   logic        m_arvalid, m_arready;
   logic [3:0]  m_arid;
   logic [31:0] m_araddr;
   logic [7:0]  m_arlen;
   logic [2:0]  m_arsize;
   logic [1:0]  m_arburst;
   logic [3:0]  m_aruser;
   logic        m_rvalid, m_rready;
   logic [3:0]  m_rid;
   logic [31:0] m_rdata;
   logic [1:0]  m_rresp;
   logic        m_rlast;
   logic [3:0]  m_ruser;
   logic        s_rvalid, s_rready;
   logic [3:0]  s_rid;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp;
   logic        s_rlast;
   logic [3:0]  s_ruser;
   logic        idle;

   easyaxi_rd_slice dut (
      .clk(clk), .rst(rst),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid),
      .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
      .s_arburst(s_arburst), .s_aruser(s_aruser),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid),
      .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
      .m_arburst(m_arburst), .m_aruser(m_aruser),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_ruser(m_ruser),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_ruser(s_ruser),
      .idle(idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   logic [63:0] ar_q[$];
   logic [63:0] r_q[$];

   always @(posedge clk) cyc++;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
   endtask

   function automatic logic [63:0] pack_ar(input logic [3:0] id, input logic [31:0] a,
      input logic [7:0] l, input logic [2:0] s, input logic [1:0] b, input logic [3:0] u);
      return {11'd0, id, a, l, s, b, u};
   endfunction

   function automatic logic [63:0] pack_r(input logic [3:0] id, input logic [31:0] d,
      input logic [1:0] rs, input logic la, input logic [3:0] u);
      return {21'd0, id, d, rs, la, u};
   endfunction

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send_ar(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
      logic hs;
      int   budget;
      s_arid    = id;
      s_araddr  = addr;
      s_arlen   = len;
      s_arsize  = 3'($urandom);
      s_arburst = 2'($urandom);
      s_aruser  = 4'($urandom);
      s_arvalid = 1'b1;
      hs = 1'b0;
      budget = 0;
      while (!hs && budget < 200) begin
         @(negedge clk);
         hs = s_arready;
         if (hs) ar_q.push_back(pack_ar(s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_aruser));
         @(posedge clk);
         budget++;
      end
      check_eq("ar_accept", 64'(hs), 64'd1);
      #1 s_arvalid = 1'b0;
   endtask

   task automatic send_r(input logic [31:0] data, input logic [3:0] id, input logic last);
      logic hs;
      int   budget;
      m_rid    = id;
      m_rdata  = data;
      m_rresp  = 2'($urandom);
      m_rlast  = last;
      m_ruser  = 4'($urandom);
      m_rvalid = 1'b1;
      hs = 1'b0;
      budget = 0;
      while (!hs && budget < 200) begin
         @(negedge clk);
         hs = m_rready;
         if (hs) r_q.push_back(pack_r(m_rid, m_rdata, m_rresp, m_rlast, m_ruser));
         @(posedge clk);
         budget++;
      end
      check_eq("r_accept", 64'(hs), 64'd1);
      #1 m_rvalid = 1'b0;
   endtask

   task automatic wait_drain();
      int b = 0;
      while ((ar_q.size() != 0 || r_q.size() != 0) && b < 500) begin
         @(posedge clk);
         b++;
      end
      check_eq("drain_empty", 64'(ar_q.size() + r_q.size()), 64'd0);
      @(negedge clk);
      check_eq("idle_after_drain", 64'(idle), 64'd1);
      @(posedge clk);
      #1;
   endtask

   // Output monitor: handshakes seen at a negedge complete on the next edge.
   logic        ar_stall_prev = 1'b0;
   logic        r_stall_prev  = 1'b0;
   logic [63:0] ar_saved, r_saved, ar_cur, r_cur;

   always @(negedge clk) begin
      ar_cur = pack_ar(m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_aruser);
      r_cur  = pack_r(s_rid, s_rdata, s_rresp, s_rlast, s_ruser);
      if (ar_stall_prev && m_arvalid) check_eq("ar_stable", ar_cur, ar_saved);
      if (r_stall_prev && s_rvalid)   check_eq("r_stable", r_cur, r_saved);
      ar_stall_prev = m_arvalid && !m_arready;
      r_stall_prev  = s_rvalid && !s_rready;
      ar_saved = ar_cur;
      r_saved  = r_cur;
      if (m_arvalid && m_arready) begin
         check_eq("ar_expected", 64'(ar_q.size() != 0), 64'd1);
         if (ar_q.size() != 0) check_eq("ar_beat", ar_cur, ar_q.pop_front());
      end
      if (s_rvalid && s_rready) begin
         check_eq("r_expected", 64'(r_q.size() != 0), 64'd1);
         if (r_q.size() != 0) check_eq("r_beat", r_cur, r_q.pop_front());
      end
   end

   logic stop_toggle;
   int   c0;

   initial begin
      rst = 1'b1;
      s_arvalid = 1'b0; s_arid = '0; s_araddr = '0; s_arlen = '0;
      s_arsize = '0; s_arburst = '0; s_aruser = '0;
      m_rvalid = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0;
      m_rlast = 1'b0; m_ruser = '0;
      m_arready = 1'b1;
      s_rready  = 1'b1;
      stop_toggle = 1'b0;

      // Reset / idle
      repeat (2) begin
         @(negedge clk);
         check_eq("rst_m_arvalid", 64'(m_arvalid), 64'd0);
         check_eq("rst_s_rvalid", 64'(s_rvalid), 64'd0);
         check_eq("rst_idle", 64'(idle), 64'd1);
         check_eq("rst_s_arready", 64'(s_arready), 64'd0);
         check_eq("rst_m_rready", 64'(m_rready), 64'd0);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_eq("arready_before_edge", 64'(s_arready), 64'd0);
      @(negedge clk);
      check_eq("arready_after_edge", 64'(s_arready), 64'd1);
      check_eq("rready_after_edge", 64'(m_rready), 64'd1);
      check_eq("idle_after_release", 64'(idle), 64'd1);
      @(posedge clk);
      #1;

      // Single AR, slave always ready
      send_ar(32'h0000_1000, 4'd3, 8'd3);
      @(negedge clk);
      check_eq("single_arvalid_on", 64'(m_arvalid), 64'd1);
      check_eq("single_idle_busy", 64'(idle), 64'd0);
      @(negedge clk);
      check_eq("single_arvalid_off", 64'(m_arvalid), 64'd0);
      check_eq("single_idle_back", 64'(idle), 64'd1);
      @(posedge clk);
      #1;

      // Back-pressure fill
      m_arready = 1'b0;
      fork
         begin
            send_ar(32'h10, 4'd1, 8'd0);
            send_ar(32'h20, 4'd2, 8'd1);
            send_ar(32'h30, 4'd3, 8'd2);
         end
         begin
            repeat (4) @(negedge clk);
            check_eq("bp_arready_low", 64'(s_arready), 64'd0);
            check_eq("bp_addr_hold", 64'(m_araddr), 64'h10);
            check_eq("bp_arvalid", 64'(m_arvalid), 64'd1);
            check_eq("bp_accepted_two", 64'(ar_q.size()), 64'd2);
            @(posedge clk);
            #1 m_arready = 1'b1;
            repeat (3) begin
               @(negedge clk);
               check_eq("bp_no_bubble", 64'(m_arvalid), 64'd1);
            end
         end
      join
      wait_drain();

      // Streaming R burst
      c0 = cyc;
      for (int i = 0; i < 4; i++) send_r(32'hA0 + 32'(i), 4'd3, (i == 3));
      check_eq("burst_cycles", 64'(cyc - c0), 64'd4);
      wait_drain();

      // Random stall on s_rready over a 64-beat stream
      fork
         begin
            while (!stop_toggle) begin
               @(posedge clk);
               #1;
               if (!stop_toggle) s_rready = 1'($urandom_range(0, 1));
            end
         end
      join_none
      for (int i = 0; i < 64; i++) send_r(32'h1000 + 32'(i), 4'($urandom), (i % 8 == 7));
      wait_drain();
      stop_toggle = 1'b1;
      @(posedge clk);
      #2 s_rready = 1'b1;
      @(posedge clk);
      #1;

      // Reset mid-transfer with both channels full
      m_arready = 1'b0;
      s_rready  = 1'b0;
      fork
         begin
            send_ar(32'h40, 4'd4, 8'd0);
            send_ar(32'h50, 4'd5, 8'd0);
         end
         begin
            send_r(32'hB0, 4'd6, 1'b0);
            send_r(32'hB1, 4'd6, 1'b1);
         end
      join
      @(negedge clk);
      check_eq("full_arready", 64'(s_arready), 64'd0);
      check_eq("full_rready", 64'(m_rready), 64'd0);
      check_eq("full_arvalid", 64'(m_arvalid), 64'd1);
      check_eq("full_rvalid", 64'(s_rvalid), 64'd1);
      #2 rst = 1'b1;
      #1;
      check_eq("async_arvalid", 64'(m_arvalid), 64'd0);
      check_eq("async_rvalid", 64'(s_rvalid), 64'd0);
      check_eq("async_idle", 64'(idle), 64'd1);
      ar_q.delete();
      r_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_arready = 1'b1;
      s_rready  = 1'b1;
      repeat (6) begin
         @(negedge clk);
         check_eq("post_rst_arvalid", 64'(m_arvalid), 64'd0);
         check_eq("post_rst_rvalid", 64'(s_rvalid), 64'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
